// File: rtl/midi_cmd_encoder.sv
// midi_cmd_encoder: turns a raw MIDI byte stream into 16-bit synth command
// words {cmd, note[6:0], velocity[7:0]} for the bank manager. Handles running
// status, channel filtering, note-on-velocity-0 as note-off, and skips
// real-time, system-common and SysEx traffic. Each command is a one-cycle
// registered pulse; o_data is 16'h0000 whenever o_valid is low.
// Optional feature macro: MIDI_PROGRAM_CHANGE_WAVE_EN (program change on the
// accepted channel emits CHANGE_WAVE, 16'h8000).
module midi_cmd_encoder #(
    parameter int unsigned CHANNEL = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic [15:0] o_data,
    output logic        o_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA1 = 2'd1,
        DATA2 = 2'd2,
        SYSEX = 2'd3
    } state_t;

    // Channel-voice message types, from status bits [6:4]
    localparam logic [2:0] TYPE_NOTE_OFF = 3'd0;
    localparam logic [2:0] TYPE_NOTE_ON  = 3'd1;
    localparam logic [2:0] TYPE_CTRL     = 3'd3;
`ifdef MIDI_PROGRAM_CHANGE_WAVE_EN
    localparam logic [2:0] TYPE_PROGRAM  = 3'd4;
`endif

    localparam logic [15:0] CMD_STOP_ALL    = 16'h7F00;
`ifdef MIDI_PROGRAM_CHANGE_WAVE_EN
    localparam logic [15:0] CMD_CHANGE_WAVE = 16'h8000;
`endif

    localparam logic [3:0] CHAN = 4'(CHANNEL);

    state_t      state_q,    state_d;
    logic [2:0]  rs_type_q,  rs_type_d;
    logic        rs_ignore_q, rs_ignore_d;
    logic [1:0]  need_cnt_q, need_cnt_d;
    logic [1:0]  data_cnt_q, data_cnt_d;
    logic [6:0]  d1_q,       d1_d;
    logic [15:0] o_data_q,   o_data_d;
    logic        o_valid_q,  o_valid_d;

    // Completion scratch values
    logic        complete;
    logic [6:0]  msg_d1;
    logic [6:0]  msg_d2;
    logic [1:0]  cnt_next;

    // Parser next-state, running-status tracking and command mapping
    always_comb begin
        state_d     = state_q;
        rs_type_d   = rs_type_q;
        rs_ignore_d = rs_ignore_q;
        need_cnt_d  = need_cnt_q;
        data_cnt_d  = data_cnt_q;
        d1_d        = d1_q;
        o_data_d    = '0;
        o_valid_d   = 1'b0;
        complete    = 1'b0;
        msg_d1      = '0;
        msg_d2      = '0;
        cnt_next    = data_cnt_q + 2'd1;

        if (i_byte_valid) begin
            if (i_byte[7]) begin
                if (i_byte[7:3] == 5'b11111) begin
                    // Real-time byte: transparent to the parser
                end else if (i_byte[7:4] != 4'hF) begin
                    // Channel-voice status: (re)start running status
                    rs_type_d   = i_byte[6:4];
                    rs_ignore_d = (i_byte[3:0] != CHAN);
                    need_cnt_d  = (i_byte[6:5] == 2'b10) ? 2'd1 : 2'd2;
                    data_cnt_d  = '0;
                    state_d     = DATA1;
                end else begin
                    // System-common / SysEx: running status is lost and any
                    // trailing data bytes fall into IDLE, which drops them
                    rs_type_d   = '0;
                    rs_ignore_d = 1'b1;
                    need_cnt_d  = '0;
                    data_cnt_d  = '0;
                    state_d     = (i_byte[3:0] == 4'h0) ? SYSEX : IDLE;
                end
            end else begin
                case (state_q)
                    DATA1, DATA2: begin
                        if (cnt_next == need_cnt_q) begin
                            complete   = 1'b1;
                            msg_d1     = (data_cnt_q == 2'd0) ? i_byte[6:0] : d1_q;
                            msg_d2     = (data_cnt_q == 2'd0) ? 7'd0 : i_byte[6:0];
                            data_cnt_d = '0;
                            state_d    = DATA1;
                        end else begin
                            d1_d       = i_byte[6:0];
                            data_cnt_d = cnt_next;
                            state_d    = DATA2;
                        end
                    end
                    default: begin
                        // IDLE and SYSEX drop data bytes
                    end
                endcase
            end
        end

        if (complete && !rs_ignore_q) begin
            case (rs_type_q)
                TYPE_NOTE_ON, TYPE_NOTE_OFF: begin
                    // Note 0 is the bank's empty marker; note 127 off aliases STOP_ALL
                    if (msg_d1 != 7'd0 && msg_d1 != 7'd127) begin
                        o_valid_d = 1'b1;
                        if (rs_type_q == TYPE_NOTE_ON && msg_d2 != 7'd0)
                            o_data_d = {1'b1, msg_d1, 1'b0, msg_d2};
                        else
                            o_data_d = {1'b0, msg_d1, 8'h00};
                    end
                end
                TYPE_CTRL: begin
                    if (msg_d1 == 7'd120 || msg_d1 == 7'd123) begin
                        o_valid_d = 1'b1;
                        o_data_d  = CMD_STOP_ALL;
                    end
                end
`ifdef MIDI_PROGRAM_CHANGE_WAVE_EN
                TYPE_PROGRAM: begin
                    o_valid_d = 1'b1;
                    o_data_d  = CMD_CHANGE_WAVE;
                end
`endif
                default: begin
                    // Aftertouch, other controllers, pitch bend: discarded
                end
            endcase
        end
    end

    // Parser state and registered command output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rs_type_q   <= '0;
            rs_ignore_q <= 1'b1;
            need_cnt_q  <= '0;
            data_cnt_q  <= '0;
            d1_q        <= '0;
            o_data_q    <= '0;
            o_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs_type_q   <= rs_type_d;
            rs_ignore_q <= rs_ignore_d;
            need_cnt_q  <= need_cnt_d;
            data_cnt_q  <= data_cnt_d;
            d1_q        <= d1_d;
            o_data_q    <= o_data_d;
            o_valid_q   <= o_valid_d;
        end
    end

    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;

endmodule

// File: tb/tb_midi_cmd_encoder.sv
// tb_midi_cmd_encoder: directed byte sequences with hand-computed command words.
module tb_midi_cmd_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic [15:0] o_data;
    logic        o_valid;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

`ifdef MIDI_PROGRAM_CHANGE_WAVE_EN
    localparam logic [15:0] EXP_PC = 16'h8000;
`else
    localparam logic [15:0] EXP_PC = 16'h0000;
`endif

    midi_cmd_encoder #(.CHANNEL(0)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_data       (o_data),
        .o_valid      (o_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one byte; check the output registered on that edge
    task automatic send(input logic [7:0] b, input logic [15:0] exp, input string tag);
        @(negedge clk);
        i_byte       = b;
        i_byte_valid = 1'b1;
        @(posedge clk);
        #1;
        i_byte_valid = 1'b0;
        check_eq({tag, ".valid"}, {15'd0, o_valid}, {15'd0, (exp != 16'h0000)});
        check_eq({tag, ".data"}, o_data, exp);
    endtask

    // One cycle with no byte: output must be back to idle
    task automatic idle_chk(input string tag);
        @(posedge clk);
        #1;
        check_eq({tag, ".idle_valid"}, {15'd0, o_valid}, 16'd0);
        check_eq({tag, ".idle_data"}, o_data, 16'h0000);
    endtask

    initial begin
        reset        = 1'b1;
        i_byte       = '0;
        i_byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset.valid", {15'd0, o_valid}, 16'd0);
        check_eq("reset.data", o_data, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // Basic note on
        send(8'h90, 16'h0000, "on.s");
        send(8'h3C, 16'h0000, "on.d1");
        send(8'h64, 16'hBC64, "on.d2");
        idle_chk("on");

        // Running status: velocity-0 note on becomes note off
        send(8'h90, 16'h0000, "rs.s");
        send(8'h3C, 16'h0000, "rs.d1");
        send(8'h64, 16'hBC64, "rs.d2");
        send(8'h40, 16'h0000, "rs.d1b");
        send(8'h00, 16'h4000, "rs.d2b");
        idle_chk("rs");

        // Other channel is ignored, including running status
        send(8'h92, 16'h0000, "ch.s");
        send(8'h3C, 16'h0000, "ch.d1");
        send(8'h64, 16'h0000, "ch.d2");
        send(8'h3E, 16'h0000, "ch.d1b");
        send(8'h10, 16'h0000, "ch.d2b");

        // Real-time byte inside a message, then sysex clears running status
        send(8'h90, 16'h0000, "rt.s");
        send(8'h3C, 16'h0000, "rt.d1");
        send(8'hF8, 16'h0000, "rt.f8");
        send(8'h64, 16'hBC64, "rt.d2");
        send(8'hF0, 16'h0000, "sx.f0");
        send(8'h01, 16'h0000, "sx.01");
        send(8'h02, 16'h0000, "sx.02");
        send(8'hF7, 16'h0000, "sx.f7");
        send(8'h3C, 16'h0000, "sx.d1");
        send(8'h40, 16'h0000, "sx.d2");

        // Controllers: all-notes-off / all-sound-off, others dropped
        send(8'hB0, 16'h0000, "cc.s");
        send(8'h7B, 16'h0000, "cc.d1");
        send(8'h00, 16'h7F00, "cc.d2");
        send(8'h78, 16'h0000, "cc.d1b");
        send(8'h00, 16'h7F00, "cc.d2b");
        send(8'h07, 16'h0000, "cc.d1c");
        send(8'h64, 16'h0000, "cc.d2c");

        // Boundary notes 0 and 127 discarded, ordinary note off
        send(8'h90, 16'h0000, "n0.s");
        send(8'h00, 16'h0000, "n0.d1");
        send(8'h40, 16'h0000, "n0.d2");
        send(8'h7F, 16'h0000, "n127.d1");
        send(8'h40, 16'h0000, "n127.d2");
        send(8'h80, 16'h0000, "off.s");
        send(8'h45, 16'h0000, "off.d1");
        send(8'h22, 16'h4500, "off.d2");
        idle_chk("off");

        // A new status aborts a partial message
        send(8'h90, 16'h0000, "ab.s");
        send(8'h3C, 16'h0000, "ab.d1");
        send(8'h80, 16'h0000, "ab.s2");
        send(8'h45, 16'h0000, "ab.d1b");
        send(8'h22, 16'h4500, "ab.d2b");

        // System common F2 then data: nothing, running status gone
        send(8'hF2, 16'h0000, "f2.s");
        send(8'h3C, 16'h0000, "f2.d1");
        send(8'h40, 16'h0000, "f2.d2");

        // 1-byte messages: program change (configurable), channel pressure
        send(8'hC0, 16'h0000, "pc.s");
        send(8'h05, EXP_PC,   "pc.d1");
        send(8'h06, EXP_PC,   "pc.rs");
        send(8'hD0, 16'h0000, "cp.s");
        send(8'h10, 16'h0000, "cp.d1");
        send(8'hC3, 16'h0000, "pcx.s");
        send(8'h05, 16'h0000, "pcx.d1");

        // Pitch bend discarded, and next data pair still parses in step
        send(8'hE0, 16'h0000, "pb.s");
        send(8'h00, 16'h0000, "pb.d1");
        send(8'h40, 16'h0000, "pb.d2");

        // Reset mid-message discards the partial message
        send(8'h90, 16'h0000, "rm.s");
        send(8'h3C, 16'h0000, "rm.d1");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rm.reset_valid", {15'd0, o_valid}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        send(8'h64, 16'h0000, "rm.d2");
        send(8'h40, 16'h0000, "rm.more");

        // Recovery after reset
        send(8'h90, 16'h0000, "rc.s");
        send(8'h3C, 16'h0000, "rc.d1");
        send(8'h64, 16'hBC64, "rc.d2");
        idle_chk("rc");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
